// File: rtl/lsu_axi_split.sv
// Load/store unit bridging single EXU requests onto an AXI4-Lite-style master port.
// Accesses crossing a DATA_W boundary are issued as two aligned beats and reassembled.
module lsu_axi_split #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  io_master_awvalid,
    input  logic                  io_master_awready,
    output logic [ADDR_W-1:0]     io_master_awaddr,
    output logic                  io_master_wvalid,
    input  logic                  io_master_wready,
    output logic [DATA_W-1:0]     io_master_wdata,
    output logic [DATA_W/8-1:0]   io_master_wstrb,
    input  logic                  io_master_bvalid,
    output logic                  io_master_bready,
    input  logic [1:0]            io_master_bresp,
    output logic                  io_master_arvalid,
    input  logic                  io_master_arready,
    output logic [ADDR_W-1:0]     io_master_araddr,
    input  logic                  io_master_rvalid,
    output logic                  io_master_rready,
    input  logic [DATA_W-1:0]     io_master_rdata,
    input  logic [1:0]            io_master_rresp
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ADDR = 3'd1;
    localparam logic [2:0] RESP = 3'd2;
    localparam logic [2:0] NEXT = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]            state;
    logic                  awvalid_q, wvalid_q, arvalid_q;
    logic                  beat_q, err_q;
    logic                  wen_q, uns_q, split_q;
    logic [1:0]            size_q;
    logic [OFF_W-1:0]      off_q;
    logic [ADDR_W-1:0]     addr_q, next_addr_q;
    logic [DATA_W-1:0]     wdata_q, hi_data_q;
    logic [BYTES-1:0]      wstrb_q, hi_strb_q;
    logic [DATA_W-1:0]     beat0_q, beat1_q;

    function automatic logic [2*DATA_W-1:0] lane_data(logic [DATA_W-1:0] d, logic [1:0] size,
                                                      logic [OFF_W-1:0] off);
        logic [2*DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < DATA_W; i++)
            if (i < (8 << size)) w[i] = d[i];
        return w << (8 * off);
    endfunction

    function automatic logic [2*BYTES-1:0] lane_strb(logic [1:0] size, logic [OFF_W-1:0] off);
        logic [2*BYTES-1:0] s;
        s = '0;
        for (int i = 0; i < 2*BYTES; i++)
            if (i >= int'(off) && i < int'(off) + (1 << size)) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] extend(logic [2*DATA_W-1:0] w, logic [1:0] size,
                                                 logic uns);
        logic [DATA_W-1:0] r;
        logic              sgn;
        int                nbits;
        nbits = 8 << size;
        sgn   = 1'b0;
        for (int i = 0; i < 2*DATA_W; i++)
            if (i == nbits - 1) sgn = w[i];
        sgn = sgn & !uns;
        for (int i = 0; i < DATA_W; i++)
            r[i] = (i < nbits) ? w[i] : sgn;
        return r;
    endfunction

    logic                  accept, illegal, req_split;
    logic [ADDR_W-1:0]     req_base;
    logic [2*DATA_W-1:0]   req_wide_data, load_wide;
    logic [2*BYTES-1:0]    req_wide_strb;
    logic                  aw_next, w_next, ar_next, beat_done, resp_bad;

    assign accept        = req_valid && (state == IDLE);
    assign illegal       = (DATA_W == 32) && (req_size == 2'd3);
    assign req_split     = (32'(req_addr[OFF_W-1:0]) + (32'd1 << req_size)) > 32'(BYTES);
    assign req_base      = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign req_wide_data = lane_data(req_wdata, req_size, req_addr[OFF_W-1:0]);
    assign req_wide_strb = lane_strb(req_size, req_addr[OFF_W-1:0]);
    assign load_wide     = {beat1_q, beat0_q} >> (8 * off_q);

    // Each valid drops on its own handshake; ADDR exits once all have dropped.
    assign aw_next   = awvalid_q && !io_master_awready;
    assign w_next    = wvalid_q && !io_master_wready;
    assign ar_next   = arvalid_q && !io_master_arready;
    assign beat_done = wen_q ? io_master_bvalid : io_master_rvalid;
    assign resp_bad  = wen_q ? (io_master_bresp != 2'd0) : (io_master_rresp != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            beat_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    beat_q <= 1'b0;
                    if (illegal) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        err_q     <= 1'b0;
                        arvalid_q <= !req_wen;
                        awvalid_q <= req_wen;
                        wvalid_q  <= req_wen;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    awvalid_q <= aw_next;
                    wvalid_q  <= w_next;
                    arvalid_q <= ar_next;
                    if (!aw_next && !w_next && !ar_next) state <= RESP;
                end
                RESP: if (beat_done) begin
                    err_q <= err_q | resp_bad;
                    if (split_q && !beat_q && !resp_bad && !err_q) begin
                        beat_q <= 1'b1;
                        state  <= NEXT;
                    end else begin
                        state <= DONE;
                    end
                end
                NEXT: begin
                    arvalid_q <= !wen_q;
                    awvalid_q <= wen_q;
                    wvalid_q  <= wen_q;
                    state     <= ADDR;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; control gating keeps stale contents invisible.
    always_ff @(posedge clk) begin
        if (accept) begin
            wen_q       <= req_wen;
            uns_q       <= req_unsigned;
            size_q      <= req_size;
            off_q       <= req_addr[OFF_W-1:0];
            split_q     <= req_split;
            addr_q      <= req_base;
            next_addr_q <= req_base + ADDR_W'(BYTES);
            wdata_q     <= req_wide_data[DATA_W-1:0];
            hi_data_q   <= req_wide_data[2*DATA_W-1:DATA_W];
            wstrb_q     <= req_wide_strb[BYTES-1:0];
            hi_strb_q   <= req_wide_strb[2*BYTES-1:BYTES];
        end
        if (state == NEXT) begin
            addr_q  <= next_addr_q;
            wdata_q <= hi_data_q;
            wstrb_q <= hi_strb_q;
        end
        if (state == RESP && io_master_rvalid && !wen_q) begin
            if (beat_q) beat1_q <= io_master_rdata;
            else        beat0_q <= io_master_rdata;
        end
    end

    assign req_ready         = (state == IDLE);
    assign io_master_awvalid = awvalid_q;
    assign io_master_wvalid  = wvalid_q;
    assign io_master_arvalid = arvalid_q;
    assign io_master_awaddr  = addr_q;
    assign io_master_araddr  = addr_q;
    assign io_master_wdata   = wdata_q;
    assign io_master_wstrb   = wstrb_q;
    assign io_master_bready  = (state == RESP) && wen_q;
    assign io_master_rready  = (state == RESP) && !wen_q;
    assign resp_valid        = (state == DONE);
    assign resp_err          = (state == DONE) && err_q;
    assign resp_rdata        = (state == DONE && !wen_q && !err_q) ? extend(load_wide, size_q, uns_q)
                                                                   : '0;
endmodule

// File: tb/tb_lsu_axi_split.sv
// Directed bench for lsu_axi_split (DATA_W=32): vector table over a simple slave model,
// plus hand sequences for write-channel stalls and reset in mid-transaction.
module tb_lsu_axi_split;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int failures = 0;

    lsu_axi_split #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .io_master_awvalid(awvalid), .io_master_awready(awready), .io_master_awaddr(awaddr),
        .io_master_wvalid(wvalid), .io_master_wready(wready), .io_master_wdata(wdata),
        .io_master_wstrb(wstrb),
        .io_master_bvalid(bvalid), .io_master_bready(bready), .io_master_bresp(bresp),
        .io_master_arvalid(arvalid), .io_master_arready(arready), .io_master_araddr(araddr),
        .io_master_rvalid(rvalid), .io_master_rready(rready), .io_master_rdata(rdata),
        .io_master_rresp(rresp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  resp0;
        int          beats;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [3:0]  s0;
        logic [3:0]  s1;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] smask(input logic [3:0] s);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
        return m;
    endfunction

    task automatic slave_default();
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        rvalid = 1'b1; bvalid = 1'b1; rresp = 2'd0; bresp = 2'd0; rdata = '0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          acnt, wcnt, rcnt, nresp, lat;
        logic [31:0] a[2];
        logic [3:0]  s[2];
        logic [31:0] w[2];
        logic [31:0] got_rd;
        logic        got_err;
        acnt = 0; wcnt = 0; rcnt = 0; nresp = 0; lat = 0;
        got_rd = '0; got_err = 1'b0;
        for (int i = 0; i < 2; i++) begin a[i] = '0; s[i] = '0; w[i] = '0; end
        @(negedge clk);
        chk($sformatf("v%0d_req_ready", idx), 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_wen = v.wen; req_addr = v.addr; req_wdata = v.wdata;
        req_size = v.size; req_unsigned = v.uns;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clk);
            rdata = (rcnt == 0) ? v.rd0 : v.rd1;
            rresp = (rcnt == 0) ? v.resp0 : 2'd0;
            bresp = (rcnt == 0) ? v.resp0 : 2'd0;
            #1;
            if (arvalid && arready) begin if (acnt < 2) a[acnt] = araddr; acnt++; end
            if (awvalid && awready) begin if (acnt < 2) a[acnt] = awaddr; acnt++; end
            if (wvalid && wready) begin
                if (wcnt < 2) begin s[wcnt] = wstrb; w[wcnt] = wdata; end
                wcnt++;
            end
            if ((rvalid && rready) || (bvalid && bready)) rcnt++;
            if (resp_valid) begin
                if (nresp == 0) begin lat = cyc + 1; got_rd = resp_rdata; got_err = resp_err; end
                nresp++;
            end
        end
        chk($sformatf("v%0d_addr_beats", idx), 32'(acnt), 32'(v.beats));
        if (v.beats >= 1) chk($sformatf("v%0d_addr0", idx), a[0], v.a0);
        if (v.beats == 2) chk($sformatf("v%0d_addr1", idx), a[1], v.a1);
        if (v.wen) begin
            chk($sformatf("v%0d_w_beats", idx), 32'(wcnt), 32'(v.beats));
            if (v.beats >= 1) begin
                chk($sformatf("v%0d_wstrb0", idx), 32'(s[0]), 32'(v.s0));
                chk($sformatf("v%0d_wdata0", idx), w[0] & smask(v.s0), v.w0 & smask(v.s0));
            end
            if (v.beats == 2) begin
                chk($sformatf("v%0d_wstrb1", idx), 32'(s[1]), 32'(v.s1));
                chk($sformatf("v%0d_wdata1", idx), w[1] & smask(v.s1), v.w1 & smask(v.s1));
            end
        end
        chk($sformatf("v%0d_resp_count", idx), 32'(nresp), 32'd1);
        chk($sformatf("v%0d_rdata", idx), got_rd, v.rdata);
        chk($sformatf("v%0d_err", idx), 32'(got_err), 32'(v.err));
        if (v.lat != 0) chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
    endtask

    vec_t vecs[14];

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b0, 32'h80000004, 32'h0, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 2'd0, 1,
                     32'h80000004, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 4};
        vecs[1]  = '{1'b0, 32'h80000006, 32'h0, 2'd2, 1'b0, 32'h11223344, 32'h55667788, 2'd0, 2,
                     32'h80000004, 32'h80000008, 4'h0, 4'h0, 32'h0, 32'h0, 32'h77881122, 1'b0, 7};
        vecs[2]  = '{1'b1, 32'h80000003, 32'h0000ABCD, 2'd1, 1'b0, 32'h0, 32'h0, 2'd0, 2,
                     32'h80000000, 32'h80000004, 4'h8, 4'h1, 32'hCD000000, 32'h000000AB, 32'h0, 1'b0, 7};
        vecs[3]  = '{1'b0, 32'h80000002, 32'h0, 2'd0, 1'b0, 32'h00800000, 32'h0, 2'd0, 1,
                     32'h80000000, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'hFFFFFF80, 1'b0, 4};
        vecs[4]  = '{1'b0, 32'h80000002, 32'h0, 2'd0, 1'b1, 32'h00800000, 32'h0, 2'd0, 1,
                     32'h80000000, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h00000080, 1'b0, 4};
        vecs[5]  = '{1'b0, 32'h80000006, 32'h0, 2'd2, 1'b0, 32'h11223344, 32'h55667788, 2'd2, 1,
                     32'h80000004, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 4};
        vecs[6]  = '{1'b0, 32'h80000000, 32'h0, 2'd3, 1'b0, 32'h12345678, 32'h0, 2'd0, 0,
                     32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2};
        vecs[7]  = '{1'b1, 32'h00000010, 32'h12345678, 2'd2, 1'b0, 32'h0, 32'h0, 2'd0, 1,
                     32'h00000010, 32'h0, 4'hF, 4'h0, 32'h12345678, 32'h0, 32'h0, 1'b0, 4};
        vecs[8]  = '{1'b0, 32'h00000103, 32'h0, 2'd1, 1'b1, 32'hAA000000, 32'h000000BB, 2'd0, 2,
                     32'h00000100, 32'h00000104, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0000BBAA, 1'b0, 7};
        vecs[9]  = '{1'b0, 32'h00000103, 32'h0, 2'd1, 1'b0, 32'hAA000000, 32'h000000FF, 2'd0, 2,
                     32'h00000100, 32'h00000104, 4'h0, 4'h0, 32'h0, 32'h0, 32'hFFFFFFAA, 1'b0, 7};
        vecs[10] = '{1'b0, 32'hFFFFFFFE, 32'h0, 2'd2, 1'b0, 32'h33440000, 32'h00001122, 2'd0, 2,
                     32'hFFFFFFFC, 32'h00000000, 4'h0, 4'h0, 32'h0, 32'h0, 32'h11223344, 1'b0, 7};
        vecs[11] = '{1'b1, 32'h00000021, 32'hFFFFFF5A, 2'd0, 1'b0, 32'h0, 32'h0, 2'd0, 1,
                     32'h00000020, 32'h0, 4'h2, 4'h0, 32'h00005A00, 32'h0, 32'h0, 1'b0, 4};
        vecs[12] = '{1'b1, 32'h00000007, 32'h11223344, 2'd2, 1'b0, 32'h0, 32'h0, 2'd2, 1,
                     32'h00000004, 32'h0, 4'h8, 4'h0, 32'h44000000, 32'h0, 32'h0, 1'b1, 4};
        vecs[13] = '{1'b1, 32'h00000008, 32'hCAFEF00D, 2'd3, 1'b0, 32'h0, 32'h0, 2'd0, 0,
                     32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2};

        rst = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'd0; req_unsigned = 1'b0;
        slave_default();
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_valids", {28'd0, awvalid, wvalid, arvalid, resp_valid}, 32'd0);
        chk("reset_readys", {30'd0, bready, rready}, 32'd0);
        chk("reset_resp_rdata", resp_rdata, 32'd0);
        chk("reset_resp_err", 32'(resp_err), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        // Write address stalled three cycles while write data goes through at once.
        @(negedge clk);
        awready = 1'b0; wready = 1'b1; bvalid = 1'b0;
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h00000040; req_wdata = 32'hA5A5A5A5;
        req_size = 2'd2; req_unsigned = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("stall_c1_aw_w", {30'd0, awvalid, wvalid}, 32'd3);
        chk("stall_c1_awaddr", awaddr, 32'h00000040);
        @(negedge clk);
        chk("stall_c2_aw_w", {30'd0, awvalid, wvalid}, 32'd2);
        chk("stall_c2_awaddr", awaddr, 32'h00000040);
        @(negedge clk);
        chk("stall_c3_aw_w", {30'd0, awvalid, wvalid}, 32'd2);
        awready = 1'b1;
        @(negedge clk);
        chk("stall_c4_aw_w", {30'd0, awvalid, wvalid}, 32'd0);
        chk("stall_c4_bready", 32'(bready), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valids", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        begin
            int pulses;
            pulses = 0;
            if (resp_valid) pulses++;
            bvalid = 1'b1;
            repeat (4) begin
                @(negedge clk);
                if (resp_valid) pulses++;
            end
            chk("midrst_no_resp", 32'(pulses), 32'd0);
        end

        // Request held during a busy load is ignored: exactly one response.
        slave_default();
        rvalid = 1'b0; rdata = 32'h0BADF00D;
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h00000200; req_size = 2'd2; req_unsigned = 1'b0;
        begin
            int pulses;
            logic [31:0] got;
            pulses = 0; got = '0;
            @(negedge clk);
            chk("busy_req_ready", 32'(req_ready), 32'd0);
            repeat (3) @(negedge clk);
            req_valid = 1'b0;
            rvalid = 1'b1;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (resp_valid) begin pulses++; got = resp_rdata; end
            end
            chk("busy_resp_count", 32'(pulses), 32'd1);
            chk("busy_rdata", got, 32'h0BADF00D);
        end

        run_vec(vecs[0], 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
